// File: rtl/pd_filter_pkg.sv
// Shared types for the CDR phase-detector vote filter: decision modes and FSM states.
package pd_filter_pkg;

    typedef enum logic [1:0] {
        PD_LEVEL  = 2'd0,
        PD_THRESH = 2'd1,
        PD_MAJ    = 2'd2
    } pd_mode_e;

    typedef enum logic {
        PD_IDLE = 1'b0,
        PD_HOLD = 1'b1
    } pd_state_e;

    // Mode 3 is reserved and behaves as LEVEL, so it is not a pulse mode.
    function automatic logic pd_is_pulse(input logic [1:0] m);
        return (m == PD_THRESH) || (m == PD_MAJ);
    endfunction

endpackage

// File: rtl/vote_window.sv
// One direction's sample window: DEPTH-bit shift register with a running ones count.
module vote_window
    import pd_filter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clear,
    input  logic             bit_in,
    output logic [CNT_W-1:0] cnt
);

    logic [DEPTH-1:0] win;
    logic             oldest;

    assign oldest = win[DEPTH-1];

    // Clear wins over shift so the sample on a decision edge is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win <= '0;
            cnt <= '0;
        end else if (clear) begin
            win <= '0;
            cnt <= '0;
        end else if (shift) begin
            win <= {win[DEPTH-2:0], bit_in};
            cnt <= cnt + CNT_W'(bit_in) - CNT_W'(oldest);
        end
    end

endmodule

// File: rtl/pd_vote_filter.sv
// Up/down vote filter between the phase detector and loop filter, with
// LEVEL / THRESH / MAJ decisions and a post-pulse hold-off.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   PD_IDLE | sampling windows and registering decisions each en=1 edge
//   PD_HOLD | post-pulse hold-off; inputs ignored, counter runs on en=1
module pd_vote_filter
    import pd_filter_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] thresh,
    input  logic             in_p,
    input  logic             in_n,
    output logic             out_p,
    output logic             out_n,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_p,
    output logic [CNT_W-1:0] cnt_n
);

    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    pd_state_e          state;
    pd_state_e          state_nxt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic [1:0]         mode_q;
    logic               mode_chg;
    logic               pulse_mode;
    logic               dec_p;
    logic               dec_n;
    logic               out_p_nxt;
    logic               out_n_nxt;
    logic               win_clr;
    logic               win_shift;
    logic signed [CNT_W:0] diff_pn;
    logic signed [CNT_W:0] diff_np;
    logic signed [CNT_W:0] thr_s;

    assign mode_chg   = (mode != mode_q);
    assign pulse_mode = pd_is_pulse(mode_q);
    assign busy       = (state == PD_HOLD);

    vote_window #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_win_p (
        .clk    (clk),
        .rst    (rst),
        .shift  (win_shift),
        .clear  (win_clr),
        .bit_in (in_p),
        .cnt    (cnt_p)
    );

    vote_window #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_win_n (
        .clk    (clk),
        .rst    (rst),
        .shift  (win_shift),
        .clear  (win_clr),
        .bit_in (in_n),
        .cnt    (cnt_n)
    );

    // Net difference needs one extra bit so +/-DEPTH fits without wrapping.
    always_comb begin
        diff_pn = $signed({1'b0, cnt_p}) - $signed({1'b0, cnt_n});
        diff_np = $signed({1'b0, cnt_n}) - $signed({1'b0, cnt_p});
        thr_s   = $signed({1'b0, thresh});
        dec_p   = 1'b0;
        dec_n   = 1'b0;
        case (mode_q)
            PD_THRESH: begin
                dec_p = (cnt_p >= thresh) && (cnt_p > cnt_n);
                dec_n = (cnt_n >= thresh) && (cnt_n > cnt_p);
            end
            PD_MAJ: begin
                dec_p = (diff_pn >= thr_s);
                dec_n = (diff_np >= thr_s) && !dec_p;
            end
            default: begin
                dec_p = (cnt_p != '0) && (cnt_n == '0);
                dec_n = (cnt_n != '0) && (cnt_p == '0);
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        out_p_nxt = 1'b0;
        out_n_nxt = 1'b0;
        win_clr   = 1'b0;
        win_shift = 1'b0;
        if (mode_chg) begin
            state_nxt = PD_IDLE;
            hold_nxt  = '0;
            win_clr   = 1'b1;
        end else if (en) begin
            case (state)
                PD_IDLE: begin
                    out_p_nxt = dec_p;
                    out_n_nxt = dec_n;
                    if (pulse_mode && (dec_p || dec_n)) begin
                        win_clr = 1'b1;
                        if (HOLDOFF > 0) begin
                            state_nxt = PD_HOLD;
                            hold_nxt  = HOLD_LOAD;
                        end
                    end else begin
                        win_shift = 1'b1;
                    end
                end
                PD_HOLD: begin
                    if (hold_cnt <= HOLD_ONE) begin
                        state_nxt = PD_IDLE;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_cnt - HOLD_ONE;
                    end
                end
                default: begin
                    state_nxt = PD_IDLE;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PD_IDLE;
            hold_cnt <= '0;
            mode_q   <= 2'd0;
            out_p    <= 1'b0;
            out_n    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            mode_q   <= mode;
            out_p    <= out_p_nxt;
            out_n    <= out_n_nxt;
        end
    end

endmodule

// File: tb/tb_pd_vote_filter.sv
// Directed scoreboard bench for pd_vote_filter at DEPTH=4, HOLDOFF=2.
module tb_pd_vote_filter;

    localparam int DEPTH   = 4;
    localparam int HOLDOFF = 2;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic             op;
        logic             on;
        logic             bz;
        logic [CNT_W-1:0] cp;
        logic [CNT_W-1:0] cn;
    } obs_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] thresh;
    logic             in_p;
    logic             in_n;
    logic             out_p;
    logic             out_n;
    logic             busy;
    logic [CNT_W-1:0] cnt_p;
    logic [CNT_W-1:0] cnt_n;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_assert;
    int    n_fail;

    pd_vote_filter #(
        .DEPTH   (DEPTH),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .thresh (thresh),
        .in_p   (in_p),
        .in_n   (in_n),
        .out_p  (out_p),
        .out_n  (out_n),
        .busy   (busy),
        .cnt_p  (cnt_p),
        .cnt_n  (cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic op, input logic on, input logic bz,
                            input logic [CNT_W-1:0] cp, input logic [CNT_W-1:0] cn,
                            input string tag);
        obs_t e;
        e.op = op; e.on = on; e.bz = bz; e.cp = cp; e.cn = cn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        obs_t  got;
        obs_t  e;
        string t;
        got.op = out_p; got.on = out_n; got.bz = busy; got.cp = cnt_p; got.cn = cnt_n;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_assert++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s observed op=%b on=%b busy=%b cp=%0d cn=%0d expected op=%b on=%b busy=%b cp=%0d cn=%0d",
                   t, got.op, got.on, got.bz, got.cp, got.cn, e.op, e.on, e.bz, e.cp, e.cn);
        end
    endtask

    // Drive one edge's inputs, queue what must be visible after that edge, check it.
    task automatic step(input logic ip, input logic inn, input logic e,
                        input logic op, input logic on, input logic bz,
                        input logic [CNT_W-1:0] cp, input logic [CNT_W-1:0] cn,
                        input string tag);
        @(negedge clk);
        in_p = ip;
        in_n = inn;
        en   = e;
        push_exp(op, on, bz, cp, cn, tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic check_now(input string tag);
        push_exp(1'b0, 1'b0, 1'b0, '0, '0, tag);
        pop_check();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst    = 1'b0;
        en     = 1'b0;
        mode   = 2'd0;
        thresh = 3'd2;
        in_p   = 1'b0;
        in_n   = 1'b0;
        #12;
        check_now("reset_state");
        @(negedge clk);
        rst = 1'b1;

        // 1: LEVEL, lone in_p
        step(1,0,1, 0,0,0, 1,0, "s1_e0");
        step(0,0,1, 1,0,0, 1,0, "s1_e1");
        step(0,0,1, 1,0,0, 1,0, "s1_e2");
        step(0,0,1, 1,0,0, 1,0, "s1_e3");
        step(0,0,1, 1,0,0, 0,0, "s1_e4");
        step(0,0,1, 0,0,0, 0,0, "s1_e5");

        // 1b: LEVEL, en=0 freezes the window and zeroes the output
        step(1,0,1, 0,0,0, 1,0, "s1b_e0");
        step(0,0,1, 1,0,0, 1,0, "s1b_e1");
        step(0,0,1, 1,0,0, 1,0, "s1b_e2");
        step(0,0,0, 0,0,0, 1,0, "s1b_en0");
        step(0,0,1, 1,0,0, 1,0, "s1b_e4");
        step(0,0,1, 1,0,0, 0,0, "s1b_e5");
        step(0,0,1, 0,0,0, 0,0, "s1b_e6");

        // 2: LEVEL, in_p then in_n
        step(1,0,1, 0,0,0, 1,0, "s2_e0");
        step(0,0,1, 1,0,0, 1,0, "s2_e1");
        step(0,1,1, 1,0,0, 1,1, "s2_e2");
        step(0,0,1, 0,0,0, 1,1, "s2_e3");
        step(0,0,1, 0,0,0, 0,1, "s2_e4");
        step(0,0,1, 0,1,0, 0,1, "s2_e5");
        step(0,0,1, 0,1,0, 0,0, "s2_e6");
        step(0,0,1, 0,0,0, 0,0, "s2_e7");

        // 3: THRESH pulse, hold-off and discarded inputs
        mode = 2'd1;
        step(0,0,0, 0,0,0, 0,0, "s3_modechg");
        step(1,0,1, 0,0,0, 1,0, "s3_e0");
        step(0,0,1, 0,0,0, 1,0, "s3_e1");
        step(1,0,1, 0,0,0, 2,0, "s3_e2");
        step(1,0,1, 1,0,1, 0,0, "s3_e3_pulse");
        step(1,0,1, 0,0,1, 0,0, "s3_e4_ignored");
        step(1,0,1, 0,0,0, 0,0, "s3_e5_ignored");
        step(1,0,1, 0,0,0, 1,0, "s3_e6_resume");
        step(0,0,1, 0,0,0, 1,0, "s3_e7");
        step(0,0,1, 0,0,0, 1,0, "s3_e8");
        step(0,0,1, 0,0,0, 1,0, "s3_e9");
        step(0,0,1, 0,0,0, 0,0, "s3_e10");

        // 4: MAJ, net +2 gives out_p
        mode = 2'd2;
        step(0,0,0, 0,0,0, 0,0, "s4_modechg");
        step(1,0,1, 0,0,0, 1,0, "s4_e0");
        step(1,1,1, 0,0,0, 2,1, "s4_e1");
        step(1,0,1, 0,0,0, 3,1, "s4_e2");
        step(0,0,1, 1,0,1, 0,0, "s4_e3_pulse");
        step(0,0,1, 0,0,1, 0,0, "s4_e4");
        step(0,0,1, 0,0,0, 0,0, "s4_e5");

        // 4b: MAJ with thresh=3, net -3 gives out_n
        thresh = 3'd3;
        step(0,1,1, 0,0,0, 0,1, "s4b_e0");
        step(0,1,1, 0,0,0, 0,2, "s4b_e1");
        step(0,1,1, 0,0,0, 0,3, "s4b_e2");
        step(0,0,1, 0,1,1, 0,0, "s4b_e3_pulse");
        step(0,0,1, 0,0,1, 0,0, "s4b_e4");
        step(0,0,1, 0,0,0, 0,0, "s4b_e5");
        thresh = 3'd2;

        // 5: THRESH, both directions together never decide
        mode = 2'd1;
        step(0,0,0, 0,0,0, 0,0, "s5_modechg");
        step(1,1,1, 0,0,0, 1,1, "s5_e0");
        step(1,1,1, 0,0,0, 2,2, "s5_e1");
        step(1,1,1, 0,0,0, 3,3, "s5_e2");
        step(1,1,1, 0,0,0, 4,4, "s5_e3_full");
        step(1,1,1, 0,0,0, 4,4, "s5_e4_sat");
        step(0,0,0, 0,0,0, 4,4, "s5_e5_frozen");
        step(0,0,0, 0,0,0, 4,4, "s5_e6_frozen");
        step(0,0,1, 0,0,0, 3,3, "s5_drain1");
        step(0,0,1, 0,0,0, 2,2, "s5_drain2");
        step(0,0,1, 0,0,0, 1,1, "s5_drain3");
        step(0,0,1, 0,0,0, 0,0, "s5_drain4");

        // 6: reset mid-HOLD, then identical replay
        step(1,0,1, 0,0,0, 1,0, "s6a_e0");
        step(0,0,1, 0,0,0, 1,0, "s6a_e1");
        step(1,0,1, 0,0,0, 2,0, "s6a_e2");
        step(0,0,1, 1,0,1, 0,0, "s6a_e3_pulse");
        step(1,0,1, 0,0,1, 0,0, "s6a_e4_hold");
        #2;
        rst = 1'b0;
        #1;
        check_now("s6_rst_in_hold");
        @(negedge clk);
        rst = 1'b1;
        step(0,0,0, 0,0,0, 0,0, "s6_modechg");
        step(1,0,1, 0,0,0, 1,0, "s6b_e0");
        step(0,0,1, 0,0,0, 1,0, "s6b_e1");
        step(1,0,1, 0,0,0, 2,0, "s6b_e2");
        step(0,0,1, 1,0,1, 0,0, "s6b_e3_pulse");
        step(1,0,1, 0,0,1, 0,0, "s6b_e4_ignored");
        step(1,0,1, 0,0,0, 0,0, "s6b_e5_ignored");
        step(1,0,1, 0,0,0, 1,0, "s6b_e6_resume");
        #2;
        rst = 1'b0;
        #1;
        check_now("s6_rst_counts");
        @(negedge clk);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
